// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin arbiter sharing one quick_spi master between NUM_REQ requesters
// Optional watchdog: define QUICK_SPI_ARB_TIMEOUT_EN to abort a transaction whose end_of_transaction
// never arrives; the aborted transaction completes with error and a one-cycle spi_enable drop.
module quick_spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int IN_WIDTH       = 8,
  parameter int SLAVES         = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_operation,
  input  logic [NUM_REQ*SLAVES-1:0]     req_slave,
  input  logic [NUM_REQ*OUT_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [IN_WIDTH-1:0]           rdata,
  output logic                          error,
  output logic                          spi_enable,
  output logic                          spi_start,
  output logic                          spi_operation,
  output logic [SLAVES-1:0]             spi_slave,
  output logic [OUT_WIDTH-1:0]          spi_outgoing_data,
  input  logic                          spi_eot,
  input  logic [IN_WIDTH-1:0]           spi_incoming_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Elaboration-time guard against unsupported configurations.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("quick_spi_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [IN_WIDTH-1:0]   rdata_q, rdata_d;
  logic                  start_q, start_d;
  logic                  op_q, op_d;
  logic [SLAVES-1:0]     slave_q, slave_d;
  logic [OUT_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  enable_q, enable_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [SUM_W-1:0]      arb_sum;

`ifdef QUICK_SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  error_q, error_d;
`endif

  // Round-robin search: first requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_sum = {1'b0, ptr_q} + SUM_W'(i);
      if (arb_sum >= SUM_W'(NUM_REQ)) arb_sum = arb_sum - SUM_W'(NUM_REQ);
      if (!win_found && req[arb_sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = arb_sum[PTR_W-1:0];
      end
    end
  end

  // Transaction sequencer: next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    start_d  = start_q;
    op_d     = op_q;
    slave_d  = slave_q;
    wdata_d  = wdata_q;
    enable_d = 1'b1;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    error_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          grant_d = ONE_HOT0 << win_idx;
          op_d    = req_operation[win_idx];
          slave_d = req_slave[win_idx*SLAVES +: SLAVES];
          wdata_d = req_wdata[win_idx*OUT_WIDTH +: OUT_WIDTH];
          state_d = S_START;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      S_WAIT: begin
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (spi_eot) begin
          if (op_q) rdata_d = spi_incoming_data;
          start_d = 1'b0;
          done_d  = grant_q;
          state_d = S_DONE;
        end
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          start_d  = 1'b0;
          done_d   = grant_q;
          error_d  = 1'b1;
          enable_d = 1'b0;
          state_d  = S_DONE;
        end
`endif
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      op_q     <= 1'b0;
      slave_q  <= '0;
      wdata_q  <= '0;
      enable_q <= 1'b0;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      op_q     <= op_d;
      slave_q  <= slave_d;
      wdata_q  <= wdata_d;
      enable_q <= enable_d;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      error_q  <= error_d;
`endif
    end
  end

  assign grant             = grant_q;
  assign done              = done_q;
  assign rdata             = rdata_q;
  assign spi_enable        = enable_q;
  assign spi_start         = start_q;
  assign spi_operation     = op_q;
  assign spi_slave         = slave_q;
  assign spi_outgoing_data = wdata_q;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
  assign error             = error_q;
`else
  assign error             = 1'b0;
`endif

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb/tb_quick_spi_arbiter.sv - scoreboard bench for quick_spi_arbiter with a behavioural quick_spi model
module tb_quick_spi_arbiter;

  localparam int NR = 4;
  localparam int OW = 16;
  localparam int IW = 8;
  localparam int SL = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_operation = '0;
  logic [NR*SL-1:0]  req_slave = '0;
  logic [NR*OW-1:0]  req_wdata = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [IW-1:0]     rdata;
  logic              error;
  logic              spi_enable;
  logic              spi_start;
  logic              spi_operation;
  logic [SL-1:0]     spi_slave;
  logic [OW-1:0]     spi_outgoing_data;
  logic              spi_eot = 1'b0;
  logic [IW-1:0]     spi_incoming_data = '0;

  quick_spi_arbiter #(
    .NUM_REQ(NR), .OUT_WIDTH(OW), .IN_WIDTH(IW), .SLAVES(SL), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_operation(req_operation),
    .req_slave(req_slave), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .error(error), .spi_enable(spi_enable), .spi_start(spi_start),
    .spi_operation(spi_operation), .spi_slave(spi_slave),
    .spi_outgoing_data(spi_outgoing_data), .spi_eot(spi_eot),
    .spi_incoming_data(spi_incoming_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NR-1:0] g;
    logic          op;
    logic [SL-1:0] sl;
    logic [OW-1:0] wd;
  } start_t;

  typedef struct {
    logic [NR-1:0] g;
    logic [IW-1:0] rd;
    logic          err;
  } done_t;

  start_t        exp_s[$];
  done_t         exp_d[$];
  logic [IW-1:0] in_q[$];

  task automatic push_s(input logic [NR-1:0] g, input logic op, input logic [SL-1:0] sl,
                        input logic [OW-1:0] wd);
    start_t s;
    s.g = g; s.op = op; s.sl = sl; s.wd = wd;
    exp_s.push_back(s);
  endtask

  task automatic push_d(input logic [NR-1:0] g, input logic [IW-1:0] rd, input logic [IW-1:0] incoming);
    done_t d;
    d.g = g; d.rd = rd; d.err = 1'b0;
    exp_d.push_back(d);
    in_q.push_back(incoming);
  endtask

  // quick_spi model: end_of_transaction eot_delay cycles after start (0 = never)
  int eot_delay = 0;
  int mcnt = 0;
  bit issued = 0;
  int last_eot_cyc = -100;

  always @(negedge clk) begin
    if (!reset_n || !spi_start) begin
      mcnt = 0;
      issued = 0;
      spi_eot = 1'b0;
    end else if (!issued) begin
      mcnt++;
      if (eot_delay != 0 && mcnt == eot_delay) begin
        spi_eot = 1'b1;
        issued = 1;
        last_eot_cyc = cyc;
        spi_incoming_data = (in_q.size() > 0) ? in_q.pop_front() : 8'hEE;
      end
    end else begin
      spi_eot = 1'b0;
    end
  end

  // Monitor: pops expectations whenever spi_start rises or done pulses
  logic   prev_start = 1'b0;
  start_t ms;
  done_t  md;

  always @(negedge clk) begin
    if (spi_start && !prev_start) begin
      if (exp_s.size() == 0) begin
        check("unexpected_start", {31'b0, spi_start}, 32'd0);
      end else begin
        ms = exp_s.pop_front();
        check("start_grant", grant, ms.g);
        check("start_op", spi_operation, ms.op);
        check("start_slave", spi_slave, ms.sl);
        check("start_wdata", spi_outgoing_data, ms.wd);
      end
    end
    prev_start = spi_start;
    if (done != '0) begin
      if (exp_d.size() == 0) begin
        check("unexpected_done", done, 32'd0);
      end else begin
        md = exp_d.pop_front();
        check("done_vec", done, md.g);
        check("done_grant", grant, md.g);
        check("done_rdata", rdata, md.rd);
        check("done_error", error, md.err);
        check("done_latency", cyc - last_eot_cyc, 32'd1);
        check("done_start_low", spi_start, 32'd0);
      end
    end
  end

  task automatic setup(input int i, input logic op, input logic [SL-1:0] sl, input logic [OW-1:0] wd);
    req_operation[i]       = op;
    req_slave[i*SL +: SL]  = sl;
    req_wdata[i*OW +: OW]  = wd;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen_%0d", i), done[i], 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!spi_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", spi_start, 32'd1);
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_error", error, 0);
    check("rst_enable", spi_enable, 0);
    check("rst_start", spi_start, 0);
    check("rst_op", spi_operation, 0);
    check("rst_slave", spi_slave, 0);
    check("rst_wdata", spi_outgoing_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("enable_after_reset", spi_enable, 1);
    check("idle_grant", grant, 0);

    // Contention: all four held, order 0,1,2,3,0; requesters 1 and 3 write
    setup(0, 1'b1, 2'd0, 16'hA000);
    setup(1, 1'b0, 2'd1, 16'hA001);
    setup(2, 1'b1, 2'd2, 16'hA002);
    setup(3, 1'b0, 2'd3, 16'hA003);
    eot_delay = 5;
    push_s(4'b0001, 1'b1, 2'd0, 16'hA000); push_d(4'b0001, 8'h31, 8'h31);
    push_s(4'b0010, 1'b0, 2'd1, 16'hA001); push_d(4'b0010, 8'h31, 8'h32);
    push_s(4'b0100, 1'b1, 2'd2, 16'hA002); push_d(4'b0100, 8'h33, 8'h33);
    push_s(4'b1000, 1'b0, 2'd3, 16'hA003); push_d(4'b1000, 8'h33, 8'h34);
    push_s(4'b0001, 1'b1, 2'd0, 16'hA000); push_d(4'b0001, 8'h35, 8'h35);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done(k % 4, 200);
    req = '0;
    repeat (3) @(negedge clk);

    // Single read by requester 1, 40-cycle transaction
    setup(1, 1'b1, 2'b01, 16'h0BAD);
    eot_delay = 40;
    push_s(4'b0010, 1'b1, 2'b01, 16'h0BAD); push_d(4'b0010, 8'h95, 8'h95);
    req = 4'b0010;
    @(negedge clk);
    check("arb_grant_latency", grant, 4'b0010);
    check("arb_start_not_yet", spi_start, 0);
    @(negedge clk);
    check("start_latency", spi_start, 1);
    wait_done(1, 100);
    req = '0;
    repeat (3) @(negedge clk);

    // Write by requester 3: rdata keeps the previous read value
    setup(3, 1'b0, 2'b10, 16'hCC81);
    eot_delay = 7;
    push_s(4'b1000, 1'b0, 2'b10, 16'hCC81); push_d(4'b1000, 8'h95, 8'h5A);
    req = 4'b1000;
    wait_done(3, 100);
    req = '0;
    repeat (3) @(negedge clk);
    check("rdata_held_after_write", rdata, 8'h95);

    // Requester 1 withdraws during WAIT; transaction still completes
    setup(1, 1'b1, 2'b11, 16'h0000);
    eot_delay = 20;
    push_s(4'b0010, 1'b1, 2'b11, 16'h0000); push_d(4'b0010, 8'h47, 8'h47);
    req = 4'b0010;
    wait_start(20);
    repeat (3) @(negedge clk);
    req = '0;
    wait_done(1, 100);
    repeat (3) @(negedge clk);

    // Reset while requester 2 waits on a transaction that never ends
    setup(2, 1'b1, 2'b00, 16'h5555);
    eot_delay = 0;
    push_s(4'b0100, 1'b1, 2'b00, 16'h5555);
    req = 4'b0100;
    wait_start(20);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_start", spi_start, 0);
    check("mid_rst_enable", spi_enable, 0);
    check("mid_rst_op", spi_operation, 0);
    check("mid_rst_slave", spi_slave, 0);
    check("mid_rst_wdata", spi_outgoing_data, 0);
    setup(0, 1'b1, 2'b01, 16'h1357);
    eot_delay = 6;
    push_s(4'b0001, 1'b1, 2'b01, 16'h1357); push_d(4'b0001, 8'hC3, 8'hC3);
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_enable", spi_enable, 1);
    check("post_rst_grant", grant, 4'b0001);
    wait_done(0, 100);
    req = '0;

    // No requests: stays idle
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_start || (grant != '0)) bad++;
    end
    check("idle_quiet", bad, 0);
    check("exp_start_left", exp_s.size(), 0);
    check("exp_done_left", exp_d.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
